// File: rtl/cache_def.sv
// Shared cache/memory definitions: line request/response types, arbiter
// state encoding, owner encoding and the winner-selection helper.
package cache_def;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;

  // Cache line request towards memory.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              rw;
    logic              valid;
  } mem_req_type;

  // Memory response (line data plus one-cycle ready strobe).
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              ready;
  } mem_data_type;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  // Owner encoding of the granted requester.
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  // Pick the winning requester; prefer_d only matters on a tie.
  function automatic logic select_owner(input logic i_valid,
                                        input logic d_valid,
                                        input logic prefer_d);
    logic owner;
    if (i_valid && d_valid) begin
      owner = prefer_d ? OWNER_D : OWNER_I;
    end else if (d_valid) begin
      owner = OWNER_D;
    end else begin
      owner = OWNER_I;
    end
    return owner;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) memory arbiter.
// A winner's whole request is latched on the IDLE->BUSY edge and presented
// to memory for the whole BUSY phase; DONE is a one-cycle gap that lets the
// owner drop its valid before the next arbitration.
// Optional feature: define MEM_ARB_RR_EN for round-robin tie breaking;
// otherwise D always wins a tie.
module mem_arbiter
  import cache_def::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  mem_req_type  i_req_i,
  input  mem_req_type  d_req_i,
  input  mem_data_type mem_data_i,
  output mem_data_type i_data_o,
  output mem_data_type d_data_o,
  output mem_req_type  mem_req_o,
  output logic         busy_o,
  output logic [31:0]  no_grant_i_o,
  output logic [31:0]  no_grant_d_o
);

  arb_state_e  r_state;
  arb_state_e  w_state_nxt;
  mem_req_type r_req;
  logic        r_owner;
  logic [31:0] r_cnt_i;
  logic [31:0] r_cnt_d;
  logic        w_grant;
  logic        w_winner;
  logic        w_prefer_d;
  logic        w_mem_ready;

`ifdef MEM_ARB_RR_EN
  logic        r_last;

  // On a tie, favour whichever side was not granted last.
  always_comb begin
    w_prefer_d = (r_last == OWNER_I);
  end

  // Remember the most recent grant; reset to I so D takes the first tie.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_last <= OWNER_I;
    end else if (w_grant) begin
      r_last <= w_winner;
    end else begin
      r_last <= r_last;
    end
  end
`else
  // Fixed priority: D always wins a tie.
  always_comb begin
    w_prefer_d = 1'b1;
  end
`endif

  // Winner selection among the currently valid requests.
  always_comb begin
    w_winner = select_owner(i_req_i.valid, d_req_i.valid, w_prefer_d);
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic and grant strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req_i.valid || d_req_i.valid) begin
          w_state_nxt = BUSY;
          w_grant     = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (mem_data_i.ready) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = BUSY;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Latch the winner's request and owner at grant; hold otherwise so the
  // memory-side request cannot move while the transaction is in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req   <= '0;
      r_owner <= OWNER_I;
    end else if (w_grant) begin
      r_req   <= (w_winner == OWNER_D) ? d_req_i : i_req_i;
      r_owner <= w_winner;
    end else begin
      r_req   <= r_req;
      r_owner <= r_owner;
    end
  end

  // Per-requester grant counters; natural 32-bit wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt_i <= 32'd0;
      r_cnt_d <= 32'd0;
    end else if (w_grant) begin
      if (w_winner == OWNER_D) begin
        r_cnt_d <= r_cnt_d + 32'd1;
        r_cnt_i <= r_cnt_i;
      end else begin
        r_cnt_i <= r_cnt_i + 32'd1;
        r_cnt_d <= r_cnt_d;
      end
    end else begin
      r_cnt_i <= r_cnt_i;
      r_cnt_d <= r_cnt_d;
    end
  end

  // Memory request and response routing; ready outside BUSY is dropped.
  always_comb begin
    mem_req_o       = r_req;
    mem_req_o.valid = (r_state == BUSY);
    w_mem_ready     = mem_data_i.ready & (r_state == BUSY);
    i_data_o.data   = mem_data_i.data;
    d_data_o.data   = mem_data_i.data;
    i_data_o.ready  = w_mem_ready & (r_owner == OWNER_I);
    d_data_o.ready  = w_mem_ready & (r_owner == OWNER_D);
  end

  assign busy_o       = (r_state != IDLE);
  assign no_grant_i_o = r_cnt_i;
  assign no_grant_d_o = r_cnt_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction table drives requests,
// expected grants go into a scoreboard queue and are checked when the DUT
// raises mem_req_o.valid; reset-in-BUSY and counter wrap are hand sequences.
module tb_mem_arbiter;
  import cache_def::*;

  logic         clk;
  logic         rst;
  mem_req_type  i_req;
  mem_req_type  d_req;
  mem_data_type mem_data;
  mem_data_type i_data;
  mem_data_type d_data;
  mem_req_type  mem_req;
  logic         busy;
  logic [31:0]  cnt_i;
  logic [31:0]  cnt_d;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] I_DATA = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam int NV = 9;

  typedef struct {
    logic         iv;
    logic         dv;
    logic [31:0]  ia;
    logic [31:0]  da;
    logic         drw;
    logic [127:0] dd;
    int           lat;
    logic         mutate;
  } vec_t;

  typedef struct {
    logic         owner_d;
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
  } exp_t;

  vec_t  vecs [NV];
  exp_t  sb_q [$];
  vec_t  v;
  exp_t  e;
  logic  exp_d;
  logic  tb_last_d;
  logic  from_done;
  int    n;
  int    exp_lat;
  logic [31:0]  tb_cnt_i;
  logic [31:0]  tb_cnt_d;
  logic [127:0] rdata;

  mem_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .i_req_i      (i_req),
    .d_req_i      (d_req),
    .mem_data_i   (mem_data),
    .i_data_o     (i_data),
    .d_data_o     (d_data),
    .mem_req_o    (mem_req),
    .busy_o       (busy),
    .no_grant_i_o (cnt_i),
    .no_grant_d_o (cnt_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench stopped by watchdog");
  end

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!mem_req.valid && cycles < 20);
  endtask

  initial begin
    // addr/data/rw fields: iv, dv, ia, da, drw, dd, lat, mutate
    vecs[0] = '{1'b0, 1'b1, 32'h0,     32'h100,   1'b0, 128'hD000_0000_0000_0000_0000_0000_0000_0001, 4, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 32'h200,   32'h0,     1'b0, 128'h0, 1, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 32'h300,   32'h400,   1'b0, 128'hD000_0000_0000_0000_0000_0000_0000_0002, 2, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 32'h300,   32'h0,     1'b0, 128'h0, 1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 32'h600,   32'h700,   1'b0, 128'hD000_0000_0000_0000_0000_0000_0000_0003, 1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 32'h600,   32'h700,   1'b0, 128'hD000_0000_0000_0000_0000_0000_0000_0003, 1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 32'h600,   32'h700,   1'b0, 128'hD000_0000_0000_0000_0000_0000_0000_0003, 1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 32'h600,   32'h700,   1'b0, 128'hD000_0000_0000_0000_0000_0000_0000_0003, 1, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 32'h0,     32'h800,   1'b1, {16{8'hA5}}, 3, 1'b1};

    rst      = 1'b1;
    i_req    = '0;
    d_req    = '0;
    mem_data = '0;
    tb_cnt_i  = 32'd0;
    tb_cnt_d  = 32'd0;
    tb_last_d = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state: every output reads zero.
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_i_data", i_data, 0);
    chk("rst_d_data", d_data, 0);
    chk("rst_cnt_i", cnt_i, 0);
    chk("rst_cnt_d", cnt_d, 0);

    // Table-driven transactions.
    from_done = 1'b0;
    for (int k = 0; k < NV; k++) begin
      v = vecs[k];
      i_req.addr  = v.ia;
      i_req.data  = I_DATA;
      i_req.rw    = 1'b0;
      i_req.valid = v.iv;
      d_req.addr  = v.da;
      d_req.data  = v.dd;
      d_req.rw    = v.drw;
      d_req.valid = v.dv;
      if (v.iv && v.dv) begin
`ifdef MEM_ARB_RR_EN
        exp_d = !tb_last_d;
`else
        exp_d = 1'b1;
`endif
      end else begin
        exp_d = v.dv;
      end
      tb_last_d = exp_d;
      e.owner_d = exp_d;
      e.addr    = exp_d ? v.da : v.ia;
      e.data    = exp_d ? v.dd : I_DATA;
      e.rw      = exp_d ? v.drw : 1'b0;
      sb_q.push_back(e);
      exp_lat = from_done ? 2 : 1;

      wait_grant(n);
      chk("grant_latency", n, exp_lat);
      if (exp_d) tb_cnt_d = tb_cnt_d + 32'd1;
      else       tb_cnt_i = tb_cnt_i + 32'd1;

      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
      end else begin
        errors++;
        $display("FAIL scoreboard_empty actual=0 required=1");
      end
      chk("grant_owner_d", (mem_req.addr == (e.owner_d ? v.da : v.ia)), 1);
      chk("grant_rw", mem_req.rw, e.rw);
      chk("busy_flag", busy, 1);
      chk("cnt_i", cnt_i, tb_cnt_i);
      chk("cnt_d", cnt_d, tb_cnt_d);

      if (v.mutate) begin
        d_req.addr  = 32'hDEAD_0000;
        d_req.data  = ~v.dd;
        d_req.rw    = ~v.drw;
        d_req.valid = 1'b0;
      end

      for (int c = 1; c <= v.lat; c++) begin
        rdata          = {96'd0, 32'hC0DE_0000} + 128'(k);
        mem_data.data  = rdata;
        mem_data.ready = (c == v.lat);
        #1;
        chk("busy_addr", mem_req.addr, e.addr);
        chk("busy_data", mem_req.data, e.data);
        chk("busy_valid", mem_req.valid, 1);
        chk("i_ready", i_data.ready, (c == v.lat) && !e.owner_d);
        chk("d_ready", d_data.ready, (c == v.lat) && e.owner_d);
        if (c == v.lat) begin
          chk("i_rdata", i_data.data, rdata);
          chk("d_rdata", d_data.data, rdata);
        end
        @(negedge clk);
      end

      // DONE: memory ready is still high here and must be ignored.
      chk("done_valid", mem_req.valid, 0);
      chk("done_busy", busy, 1);
      chk("done_i_ready", i_data.ready, 0);
      chk("done_d_ready", d_data.ready, 0);
      mem_data.ready = 1'b0;
      if (e.owner_d) d_req.valid = 1'b0;
      else           i_req.valid = 1'b0;
      from_done = 1'b1;
    end

    i_req = '0;
    d_req = '0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Reset in the second BUSY cycle abandons the transaction.
    d_req.addr  = 32'h500;
    d_req.data  = 128'h5;
    d_req.rw    = 1'b0;
    d_req.valid = 1'b1;
    wait_grant(n);
    chk("rst_seq_grant", n, 1);
    @(negedge clk);
    rst         = 1'b1;
    d_req.valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tb_cnt_i  = 32'd0;
    tb_cnt_d  = 32'd0;
    tb_last_d = 1'b0;
    chk("midrst_valid", mem_req.valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cnt_i", cnt_i, 0);
    chk("midrst_cnt_d", cnt_d, 0);
    mem_data.ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("late_i_ready", i_data.ready, 0);
      chk("late_d_ready", d_data.ready, 0);
      @(negedge clk);
      chk("late_busy", busy, 0);
    end
    mem_data.ready = 1'b0;

    // Grant counter wrap.
    force dut.r_cnt_i = 32'hFFFF_FFFF;
    #1;
    release dut.r_cnt_i;
    #1;
    chk("wrap_preload", cnt_i, 32'hFFFF_FFFF);
    i_req.addr  = 32'h900;
    i_req.data  = I_DATA;
    i_req.rw    = 1'b0;
    i_req.valid = 1'b1;
    wait_grant(n);
    chk("wrap_grant", n, 1);
    chk("wrap_cnt_i", cnt_i, 0);
    chk("wrap_cnt_d", cnt_d, 0);
    mem_data.ready = 1'b1;
    #1;
    chk("wrap_i_ready", i_data.ready, 1);
    @(negedge clk);
    mem_data.ready = 1'b0;
    i_req.valid    = 1'b0;
    @(negedge clk);
    chk("wrap_end_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  synchronous active-high reset.
- i_req_i  in  mem_req_type  I-cache line request (addr, data, rw, valid).
- d_req_i  in  mem_req_type  D-cache line request.
- mem_data_i  in  mem_data_type  memory response (data, ready).
- i_data_o  out  mem_data_type  response routed to the I-cache.
- d_data_o  out  mem_data_type  response routed to the D-cache.
- mem_req_o  out  mem_req_type  request forwarded to memory.
- busy_o  out  1  high when the FSM is not in IDLE.
- no_grant_i_o  out  32  I-cache grant count.
- no_grant_d_o  out  32  D-cache grant count.

Function
REQ-003 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-004 IDLE: if either req.valid=1, the block SHALL choose a winner, latch the winner's whole request, record the owner, and enter BUSY on the next edge; otherwise it SHALL stay in IDLE.
REQ-005 Fixed-priority mode: when both requests are valid in the same cycle, D SHALL win.
REQ-006 mem_req_o SHALL be driven from the latched register only, so it is stable throughout BUSY; mem_req_o.valid=1 only in BUSY.
REQ-007 BUSY: when mem_data_i.ready=1, the block SHALL enter DONE on the next edge; otherwise it SHALL stay in BUSY with no timeout.
REQ-008 Response routing SHALL be combinational:
- the owner's data_o.ready = mem_data_i.ready & (state==BUSY);
- the non-owner's data_o.ready = 0;
- both data_o.data = mem_data_i.data.
REQ-009 DONE SHALL last exactly 1 cycle with mem_req_o.valid=0, then go to IDLE. This lets the owner's cache FSM drop its valid so a stale request is not re-granted.
REQ-010 Minimum occupancy per transaction SHALL be 3 cycles (IDLE, BUSY with ready, DONE). The grant-to-memory latency is 1 cycle.
REQ-011 A requester dropping valid during BUSY SHALL NOT abort the transaction; the transaction completes and the ready pulse is still issued.
REQ-012 Grant counters SHALL increment by 1 on each IDLE->BUSY transition for the winner, and SHALL wrap from 0xFFFF_FFFF to 0.
REQ-013 mem_data_i.ready seen in IDLE or DONE SHALL be ignored.

Reset
REQ-014 While rst_i=1 at a clock edge:
- state SHALL be set to IDLE;
- the latched request, owner and last-grant pointer SHALL be cleared to 0;
- both counters SHALL be cleared to 0.
REQ-015 After reset, all outputs SHALL read 0, including mem_req_o.valid, busy_o and both ready signals.
REQ-016 Reset mid-BUSY SHALL abandon the transaction; a later memory ready SHALL be dropped per REQ-013.

Configuration
REQ-017 Macro MEM_ARB_RR_EN defined: when both requesters are valid in IDLE, the one not granted last SHALL win. A 1-bit last-grant register updates on each grant and resets to I, so D wins the first tie.
REQ-018 Macro MEM_ARB_RR_EN undefined: fixed D priority per REQ-005, with no last-grant register.

Structure
REQ-019 mem_req_type and mem_data_type SHALL come from the shared cache_def package.
REQ-020 The state enum (arb_state_e) and the owner encoding (OWNER_I=0, OWNER_D=1) SHALL also go in cache_def.
REQ-021 The block SHALL be flat, with no sub-module; the target size is 120-250 lines.

Verification
REQ-022 Single D request: d_req valid, addr=0x100, rw=0; memory ready 4 cycles after grant.
- Required: mem_req_o.addr=0x100 for the 4 BUSY cycles.
- Required: d_data_o.ready pulses once; i_data_o.ready stays 0; no_grant_d_o=1.
REQ-023 Simultaneous I and D requests, fixed mode: D is served first and I afterwards. The I grant occurs exactly 1 cycle after DONE; counters read 1 and 1.
REQ-024 Same stimulus with MEM_ARB_RR_EN, both held valid for 4 transactions: grant order SHALL be D, I, D, I.
REQ-025 Reset mid-transaction: assert rst_i in the 2nd BUSY cycle, then drive ready.
- Required: mem_req_o.valid=0 and busy_o=0 after the reset edge.
- Required: no ready pulse on either response port; counters read 0.
REQ-026 Write request: d_req rw=1, data=0xA5..A5.
- Required: mem_req_o.data matches and is stable until ready.
- Required: d_req changing during BUSY does not alter mem_req_o.
REQ-027 Counter wrap: force no_grant_i_o to 0xFFFF_FFFF, then issue one I grant; required: counter reads 0.
